fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `datapath`. It generates sequential fetch addresses, issues them to an instruction memory over a valid/ready request channel, and collects the in-order responses in a small prefetch FIFO. It presents each instruction with its PC to the datapath through a valid/ready handshake. A redirect from branch/jump resolution flushes all fetched and in-flight instructions and restarts fetch at the new PC.

---
 rtl/riscp_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscp_pkg.sv
// Shared fetch-side types and constants: PC arithmetic helpers and the
// prefetch FIFO entry layout.
package riscp_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 2;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_STEP);
  endfunction

  // Instructions are halfword aligned; bit 0 of any target is discarded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries: wrap-around pointers, occupancy count and a
// flush that empties it in one cycle. Head output is zero while empty.
module fetch_fifo
  import riscp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output logic                       head_valid,
  output fetch_entry_t               head_entry,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_valid = (count_q != '0);
  assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential request generation with credit-based flow
// control, in-order response collection and redirect flush with stale drop.
module fetch_unit
  import riscp_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_live, fifo_push;
  fetch_entry_t    push_entry, head_entry;

  always_comb begin
    credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
    // Gated by rst_n so no request is presented while reset is held.
    mem_req_valid = rst_n && !redirect && (credit_used < DEPTH_L);
    mem_req_addr  = fetch_pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_live      = mem_rsp_valid && (outstanding_q != '0);
    fifo_push     = rsp_live && (drop_cnt_q == '0) && !redirect;
    push_entry    = '{instr: mem_rsp_data, pc: rsp_pc_q};

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_live);
    drop_cnt_d    = drop_cnt_q;

    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      // Everything still in flight is stale, including a same-cycle response.
      drop_cnt_d = outstanding_q - CW'(rsp_live);
    end else begin
      if (req_fire)  fetch_pc_d = next_pc(fetch_pc_q);
      if (fifo_push) rsp_pc_d   = next_pc(rsp_pc_q);
      if (rsp_live && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (instr_ready),
    .head_valid (instr_valid),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  assign instr    = head_entry.instr;
  assign instr_pc = head_entry.pc;

  a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (outstanding_q != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (fifo_count != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-programmable in-order memory and a
// queue-based model of the fetch stream predict every visible output.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  rsp_t        mq[$];
  ent_t        mf[$];
  int          m_out, m_drop, cyc, last_due, lat, nreq;
  logic [31:0] m_fpc, m_rpc;
  logic        ctl_rdy, ctl_irdy, ctl_redir, rand_lat;
  logic [31:0] ctl_rpc;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mf.delete();
    m_out = 0; m_drop = 0; m_fpc = 32'h0; m_rpc = 32'h0;
    last_due = cyc;
  endtask

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic step();
    logic rsp, exp_rv, fire;
    int   out_before, due;
    ent_t e;
    rsp           = (mq.size() > 0) && (mq[0].due <= cyc);
    mem_req_ready = ctl_rdy;
    instr_ready   = ctl_irdy;
    redirect      = ctl_redir;
    redirect_pc   = ctl_rpc;
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mq[0].data : $urandom;
    #1;
    exp_rv = !ctl_redir && (mf.size() + m_out < DEPTH);
    chk("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", mem_req_addr, m_fpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, mf.size() != 0});
    if (mf.size() != 0) begin
      chk("instr", instr, mf[0].instr);
      chk("instr_pc", instr_pc, mf[0].pc);
    end
    if (mem_req_valid && ctl_rdy) nreq++;
    out_before = m_out;
    fire = exp_rv && ctl_rdy;
    if (fire) begin
      if (rand_lat) lat = $urandom_range(1, 4);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due: due, data: mem_word(m_fpc)});
      m_fpc = m_fpc + 2;
      m_out++;
    end
    if (rsp) begin
      void'(mq.pop_front());
      m_out--;
    end
    if (mf.size() != 0 && ctl_irdy) void'(mf.pop_front());
    if (ctl_redir) begin
      mf.delete();
      m_drop = out_before - (rsp ? 1 : 0);
      m_fpc = ctl_rpc & ~32'h1;
      m_rpc = ctl_rpc & ~32'h1;
    end else if (rsp) begin
      if (m_drop > 0) m_drop--;
      else begin
        e.instr = mem_word(m_rpc);
        e.pc    = m_rpc;
        mf.push_back(e);
        m_rpc = m_rpc + 2;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ctl_redir = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    ctl_rdy = 1'b0; ctl_irdy = 1'b1;
    for (int i = 0; i < 40 && (m_out != 0 || mf.size() != 0); i++) step();
    chk("drain_done", {31'b0, instr_valid}, 32'h0);
  endtask

  // Wait until an instruction is presented, then check its PC and consume it.
  task automatic expect_pc(input string tag, input logic [31:0] pc);
    int i;
    for (i = 0; i < 20 && !instr_valid; i++) step();
    chk(tag, instr_valid ? instr_pc : 32'hDEAD_BEEF, pc);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_req_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    ctl_rdy = 1'b1; ctl_irdy = 1'b1; ctl_redir = 1'b0; ctl_rpc = '0;
    rand_lat = 1'b0; lat = 1; cyc = 0; nreq = 0;
    model_reset();
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Streaming at latency 1, consumer always ready.
    lat = 1;
    run(20);

    // Consumer stalled: credits cap requests at DEPTH.
    drain();
    nreq = 0; ctl_rdy = 1'b1; ctl_irdy = 1'b0;
    run(12);
    chk("stall_req_count", nreq, 4);
    chk("stall_fifo_count", 32'(dut.fifo_count), 4);
    ctl_irdy = 1'b1;
    run(6);

    // Latency 3, redirect to an odd target with three requests in flight.
    drain();
    lat = 3; ctl_rdy = 1'b1; ctl_irdy = 1'b1;
    for (int i = 0; i < 20 && m_out != 3; i++) step();
    chk("three_outstanding", 32'(dut.outstanding_q), 3);
    ctl_redir = 1'b1; ctl_rpc = 32'h0000_0041;
    step();
    expect_pc("redir_first_pc", 32'h40);
    expect_pc("redir_second_pc", 32'h42);
    run(6);

    // Redirect coinciding with a response and a pop.
    lat = 2; ctl_irdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && mf.size() > 0 && m_out >= 2) break;
      step();
    end
    ctl_redir = 1'b1; ctl_rpc = 32'h0000_0100;
    step();
    chk("same_cycle_drop", 32'(dut.drop_cnt_q), 32'(m_out));
    expect_pc("after_same_cycle_pc", 32'h100);
    run(6);

    // Memory not ready for five cycles: address holds, nothing skipped.
    drain();
    lat = 1; ctl_rdy = 1'b0; ctl_irdy = 1'b1;
    run(5);
    ctl_rdy = 1'b1;
    run(10);

    // Address wrap past the top of memory.
    lat = 2;
    ctl_redir = 1'b1; ctl_rpc = 32'hFFFF_FFFC;
    step();
    expect_pc("wrap_pc0", 32'hFFFF_FFFC);
    expect_pc("wrap_pc1", 32'hFFFF_FFFE);
    expect_pc("wrap_pc2", 32'h0000_0000);
    run(6);

    // Random traffic with random latency and occasional redirects.
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ctl_rdy  = ($urandom_range(0, 3) != 0);
      ctl_irdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        ctl_redir = 1'b1;
        ctl_rpc   = $urandom;
      end
      step();
    end
    rand_lat = 1'b0;

    // Reset asserted mid-operation clears everything at once.
    lat = 1; ctl_rdy = 1'b1; ctl_irdy = 1'b0;
    run(3);
    #2;
    rst_n = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("midrst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("midrst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    chk("midrst_outstanding", 32'(dut.outstanding_q), 32'h0);
    model_reset();
    @(negedge clk); @(negedge clk);
    cyc += 2;
    last_due = cyc;
    rst_n = 1'b1;
    ctl_irdy = 1'b1;
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
